// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: responder FSM encoding and the SPI mode edge table.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package spi_slave_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Mode table shared with the initiator: 1 when data is sampled on the
  // rising SCLK edge. Modes 0 and 3 sample on rise, modes 1 and 2 on fall.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol ~^ cpha;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// N-stage synchronizer for one asynchronous pin, with a history flop for edge detect.
// Latency: STAGES cycles to q; rise/fall are valid in the cycle q changes.
// Backpressure: none; free-running on every clock.
module spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic c,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  // Shift the pin through the synchronizer and keep one cycle of history.
  always_ff @(posedge c) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      hist  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      hist  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled SCLK/MOSI/CS, W-bit words shifted MSB first both ways.
// Latency: rx_valid SYNC_STAGES+2 cycles after the last sampling SCLK edge at the pin.
// Backpressure: none; the master paces everything, txd must be ready when tx_load pulses.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int W           = 8,
  parameter int CPOL        = 1,
  parameter int CPHA        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         c,
  input  logic         rst,
  input  logic         sclk,
  input  logic         mosi,
  input  logic         cs,
  output logic         miso,
  output logic         miso_oe,
  input  logic [W-1:0] txd,
  output logic         tx_load,
  output logic [W-1:0] rxd,
  output logic         rx_valid,
  output logic         aborted,
  output logic         busy
);

  localparam int            CW          = $clog2(W + 1);
  localparam logic [CW-1:0] W_CNT       = CW'(W);
  localparam logic          SAMPLE_RISE = sample_on_rise(1'(CPOL), 1'(CPHA));
  localparam logic          CPHA_B      = 1'(CPHA);

  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic cs_s, cs_rise, cs_fall;
  logic sample_edge, drive_edge;
  logic unused_sync;

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-1:0]  rx_shift_q, rx_shift_d;
  logic [W-1:0]  tx_shift_q, tx_shift_d;
  logic [W-1:0]  rxd_d;
  logic          rx_valid_d, tx_load_d, aborted_d;
  // hold: next drive edge must not shift (CPHA=1 word start)
  // reload: next drive edge fetches a fresh word from txd
  logic          hold_q, hold_d;
  logic          reload_q, reload_d;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sync_sclk (
    .c(c), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .c(c), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .c(c), .rst(rst), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall};
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign drive_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

  // Next-state and next-output logic for the responder.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rxd_d      = rxd;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    aborted_d  = 1'b0;
    hold_d     = hold_q;
    reload_d   = reload_q;

    // Word delivery runs in either state so a word completed together with
    // CS release is still handed over.
    if (bit_cnt_q == W_CNT) begin
      rxd_d      = rx_shift_q;
      rx_valid_d = 1'b1;
      bit_cnt_d  = '0;
      if (state_q == ST_ACTIVE) begin
        reload_d = 1'b1;
        hold_d   = CPHA_B;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          tx_shift_d = txd;
          tx_load_d  = 1'b1;
          bit_cnt_d  = '0;
          hold_d     = CPHA_B;
          reload_d   = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (sample_edge && bit_cnt_q != W_CNT) begin
          rx_shift_d = {rx_shift_q[W-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + CW'(1);
        end
        if (drive_edge) begin
          if (reload_q) begin
            tx_shift_d = txd;
            tx_load_d  = 1'b1;
          end else if (!hold_q) begin
            tx_shift_d = tx_shift_q << 1;
          end
          hold_d   = 1'b0;
          reload_d = 1'b0;
        end
        if (cs_rise) begin
          state_d = ST_IDLE;
          // A count of W here means the word just completed: deliver, not abort.
          if (bit_cnt_d != '0 && bit_cnt_d != W_CNT) begin
            aborted_d = 1'b1;
            bit_cnt_d = '0;
          end
          hold_d   = 1'b0;
          reload_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge c) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      hold_q     <= 1'b0;
      reload_q   <= 1'b0;
      rxd        <= '0;
      rx_valid   <= 1'b0;
      tx_load    <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      reload_q   <= reload_d;
      rxd        <= rxd_d;
      rx_valid   <= rx_valid_d;
      tx_load    <= tx_load_d;
      aborted    <= aborted_d;
    end
  end

  assign miso_oe = (state_q == ST_ACTIVE);
  assign miso    = (state_q == ST_ACTIVE) & tx_shift_q[W-1];
  assign busy    = ~cs_s;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave in mode 3 (W=8) and mode 0 (W=26).
// Latency: fixed-cycle master model, SCLK period 16 system clocks.
// Backpressure: none; monitors count strobes on the falling system clock edge.
module tb_spi_slave;

  logic c = 1'b0;
  logic rst;

  // mode 3, W=8 instance
  logic        sclk3, mosi3, cs3, miso3, oe3, txl3, rxv3, ab3, busy3;
  logic [7:0]  txd3, rxd3;
  // mode 0, W=26 instance
  logic        sclk0, mosi0, cs0, miso0, oe0, txl0, rxv0, ab0, busy0;
  logic [25:0] txd0, rxd0;

  int n_checks = 0;
  int n_errors = 0;

  int rxv3_cnt = 0, txl3_cnt = 0, ab3_cnt = 0, oe3_cnt = 0, rxv0_cnt = 0;
  logic [7:0] rxq3[$];

  always #5 c = ~c;

  spi_slave #(.W(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_m3 (
    .c(c), .rst(rst), .sclk(sclk3), .mosi(mosi3), .cs(cs3),
    .miso(miso3), .miso_oe(oe3), .txd(txd3), .tx_load(txl3),
    .rxd(rxd3), .rx_valid(rxv3), .aborted(ab3), .busy(busy3)
  );

  spi_slave #(.W(26), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_m0 (
    .c(c), .rst(rst), .sclk(sclk0), .mosi(mosi0), .cs(cs0),
    .miso(miso0), .miso_oe(oe0), .txd(txd0), .tx_load(txl0),
    .rxd(rxd0), .rx_valid(rxv0), .aborted(ab0), .busy(busy0)
  );

  // Strobe monitors, sampled away from the active edge.
  always @(negedge c) begin
    if (rxv3) begin
      rxv3_cnt++;
      rxq3.push_back(rxd3);
    end
    if (txl3) txl3_cnt++;
    if (ab3)  ab3_cnt++;
    if (oe3)  oe3_cnt++;
    if (rxv0) rxv0_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge c);
    #1;
  endtask

  // Mode 3 master: drive on falling edge, capture miso just before rising edge.
  task automatic m3_word(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      sclk3 = 1'b0;
      mosi3 = tx[i];
      cyc(8);
      rx    = {rx[6:0], miso3};
      sclk3 = 1'b1;
      cyc(8);
    end
  endtask

  task automatic m3_begin();
    cs3 = 1'b0;
    cyc(8);
  endtask

  task automatic m3_end();
    cyc(4);
    cs3 = 1'b1;
    cyc(10);
  endtask

  initial begin
    logic [7:0]  g1, g2;
    logic [25:0] g0;
    logic [25:0] tx0;
    int rv, tl, ab, oe, rv0;

    rst = 1'b1;
    sclk3 = 1'b1; mosi3 = 1'b0; cs3 = 1'b1; txd3 = 8'h00;
    sclk0 = 1'b0; mosi0 = 1'b0; cs0 = 1'b1; txd0 = 26'h0;
    cyc(5);
    check("rst_rxd",      rxd3,  8'h00);
    check("rst_rx_valid", rxv3,  1'b0);
    check("rst_tx_load",  txl3,  1'b0);
    check("rst_aborted",  ab3,   1'b0);
    check("rst_busy",     busy3, 1'b0);
    check("rst_miso_oe",  oe3,   1'b0);
    check("rst_miso",     miso3, 1'b0);
    check("rst_rxd_m0",   rxd0,  26'h0);
    rst = 1'b0;
    cyc(5);

    // single word, mode 3
    txd3 = 8'hA5;
    rv = rxv3_cnt; tl = txl3_cnt; ab = ab3_cnt;
    m3_begin();
    check("t1_busy", busy3, 1'b1);
    check("t1_oe",   oe3,   1'b1);
    m3_word(8'h3C, 8, g1);
    m3_end();
    check("t1_rxd",      rxd3,           8'h3C);
    check("t1_rxv_cnt",  rxv3_cnt - rv,  1);
    check("t1_master",   g1,             8'hA5);
    check("t1_txl_cnt",  txl3_cnt - tl,  1);
    check("t1_ab_cnt",   ab3_cnt - ab,   0);
    check("t1_oe_after", oe3,            1'b0);

    // two words under one CS
    txd3 = 8'h12;
    rxq3.delete();
    rv = rxv3_cnt; tl = txl3_cnt;
    m3_begin();
    txd3 = 8'h34;
    m3_word(8'hF0, 8, g1);
    m3_word(8'h0F, 8, g2);
    m3_end();
    check("t2_rxv_cnt", rxv3_cnt - rv, 2);
    check("t2_rxq_size", rxq3.size(), 2);
    while (rxq3.size() < 2) rxq3.push_back(8'hxx);
    check("t2_rx0",     rxq3[0], 8'hF0);
    check("t2_rx1",     rxq3[1], 8'h0F);
    check("t2_master0", g1, 8'h12);
    check("t2_master1", g2, 8'h34);
    check("t2_txl_cnt", txl3_cnt - tl, 2);

    // abort after 5 sample edges, then a clean word
    txd3 = 8'h55;
    rv = rxv3_cnt; ab = ab3_cnt;
    m3_begin();
    m3_word(8'hC7, 5, g1);
    m3_end();
    check("t3_ab_cnt",  ab3_cnt - ab,  1);
    check("t3_rxv_cnt", rxv3_cnt - rv, 0);
    check("t3_rxd_kept", rxd3, 8'h0F);
    m3_begin();
    m3_word(8'h81, 8, g1);
    m3_end();
    check("t3_rxd_next", rxd3, 8'h81);
    check("t3_ab_total", ab3_cnt - ab, 1);
    check("t3_master",   g1, 8'h55);

    // reset in the middle of a word
    rv = rxv3_cnt; tl = txl3_cnt; ab = ab3_cnt;
    m3_begin();
    m3_word(8'hE6, 3, g1);
    rst = 1'b1; cs3 = 1'b1; sclk3 = 1'b1;
    cyc(6);
    check("t4_rxd",      rxd3,  8'h00);
    check("t4_rx_valid", rxv3,  1'b0);
    check("t4_tx_load",  txl3,  1'b0);
    check("t4_aborted",  ab3,   1'b0);
    check("t4_busy",     busy3, 1'b0);
    check("t4_miso_oe",  oe3,   1'b0);
    check("t4_miso",     miso3, 1'b0);
    rst = 1'b0;
    cyc(10);
    check("t4_ab_cnt",  ab3_cnt - ab,  0);
    check("t4_rxv_cnt", rxv3_cnt - rv, 0);
    txd3 = 8'hC3;
    m3_begin();
    m3_word(8'h5A, 8, g1);
    m3_end();
    check("t4_rxd_next", rxd3, 8'h5A);
    check("t4_master",   g1,   8'hC3);

    // SCLK toggling with CS high is ignored
    rv = rxv3_cnt; tl = txl3_cnt; oe = oe3_cnt;
    for (int i = 0; i < 8; i++) begin
      sclk3 = ~sclk3;
      mosi3 = 1'($urandom_range(0, 1));
      cyc(8);
    end
    cyc(6);
    check("t5_rxv_cnt", rxv3_cnt - rv, 0);
    check("t5_txl_cnt", txl3_cnt - tl, 0);
    check("t5_oe_cnt",  oe3_cnt - oe,  0);

    // mode 0, W=26
    tx0  = 26'h1514271;
    txd0 = 26'h2AAAAAA;
    rv0  = rxv0_cnt;
    g0   = 26'h0;
    cs0  = 1'b0;
    cyc(8);
    check("t6_oe",        oe0,   1'b1);
    check("t6_first_bit", miso0, 1'b1);
    for (int i = 25; i >= 0; i--) begin
      mosi0 = tx0[i];
      cyc(8);
      g0    = {g0[24:0], miso0};
      sclk0 = 1'b1;
      cyc(8);
      sclk0 = 1'b0;
    end
    cyc(8);
    cs0 = 1'b1;
    cyc(10);
    check("t6_rxd",     rxd0, 26'h1514271);
    check("t6_master",  g0,   26'h2AAAAAA);
    check("t6_rxv_cnt", rxv0_cnt - rv0, 1);
    check("t6_aborted_never", ab0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder; the peripheral-side counterpart of the team's SPI initiator.
- Sits behind FPGA pins driven by an external SPI master (host MCU or test fixture).
- Oversamples SCLK/MOSI/CS on the system clock and shifts W-bit words in both directions.
- Presents each received word with a one-cycle valid strobe and accepts the next TX word through a load strobe; supports multi-word transfers under one CS assertion.

Parameters:
- W, 8: bits per word (2..32).
- CPOL, 1: SCLK idle level.
- CPHA, 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- SYNC_STAGES, 2: synchronizer depth on sclk/mosi/cs (2 or 3).

Ports:
- c, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- sclk, input, 1: SPI clock from master (asynchronous).
- mosi, input, 1: master data out (asynchronous).
- cs, input, 1: chip select, active low (asynchronous).
- miso, output, 1: data to master.
- miso_oe, output, 1: tristate enable for miso pad; 1 while selected.
- txd, input, W: next word to transmit.
- tx_load, output, 1: 1-cycle pulse; txd captured this cycle.
- rxd, output, W: last complete received word; held until next word completes.
- rx_valid, output, 1: 1-cycle pulse; rxd updated this cycle.
- aborted, output, 1: 1-cycle pulse; CS deasserted mid-word.
- busy, output, 1: high while synchronized CS is asserted.

Behaviour:
- Reset: rxd=0, rx_valid=0, tx_load=0, aborted=0, busy=0, miso_oe=0, miso=0, state=ST_IDLE, bit_cnt=0, shift registers=0. Reset mid-word abandons the word silently: no aborted pulse, no rx_valid.
- Input conditioning: sclk, mosi and cs each pass through SYNC_STAGES flops, plus one history flop on sclk and cs for edge detection.
  - lead_edge = sclk edge leaving CPOL level; trail_edge = edge returning to it.
  - sample_edge = CPHA ? trail_edge : lead_edge.
  - drive_edge = the other edge.
- Constraints: SCLK high and low phases >= 4 c cycles each; CS falling to first SCLK edge >= 4 c cycles. Behaviour outside these constraints is undefined; the bench must not violate them.
- States:
  - ST_IDLE: miso_oe=0. On synchronized cs falling: capture txd into tx_shift, pulse tx_load, bit_cnt=0, go to ST_ACTIVE.
  - ST_ACTIVE: miso_oe=1; miso = tx_shift[W-1].
    - On sample_edge: rx_shift = {rx_shift[W-2:0], mosi_s}; bit_cnt++.
    - When bit_cnt reaches W on a sample_edge, the next cycle loads rxd from rx_shift, pulses rx_valid and clears bit_cnt.
    - On drive_edge with CPHA=0: if the word is complete (bit_cnt==0 after a full word), reload tx_shift from txd and pulse tx_load; otherwise shift tx_shift left by one.
    - On drive_edge with CPHA=1: the first drive_edge of a word does not shift, and the word's tx_load/reload happens at word start. Every later drive_edge shifts left.
    - Net effect: MSB first, always.
    - On synchronized cs rising: if bit_cnt != 0, pulse aborted and discard the partial word (rxd unchanged). Then go to ST_IDLE, miso_oe=0, miso=0.
- Word boundary under held CS: the next word's txd is captured exactly once per word via tx_load, and the first bit of the new word is on miso before its first sample_edge.
- Simultaneous events: cs rising in the same cycle as the W-th sample_edge is a complete word. rx_valid fires and aborted does not.
- Latency: rx_valid asserts SYNC_STAGES+2 c cycles after the W-th sampling SCLK edge at the pin.
- Idle: sclk toggling while cs is high is ignored; bit_cnt stays 0.
- bit_cnt width: clog2(W+1); no wrap beyond W.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE and ST_ACTIVE, 1-bit state register;
  - edge-select derivation by (CPOL, CPHA), shared with the initiator's mode table.
- One sub-module: spi_slave_sync, a parameterized N-stage synchronizer plus history flop with rise/fall outputs. Instantiate it three times.

Test Plan:
- Mode 3, W=8, txd=0xA5, master sends 0x3C at SCLK period 16c:
  - rxd=0x3C with a single rx_valid pulse;
  - master captures 0xA5 (miso bits 1,0,1,0,0,1,0,1);
  - one tx_load pulse.
- Two words under one CS: txd 0x12 then 0x34 (bench updates txd after first tx_load); master sends 0xF0, 0x0F:
  - two rx_valid pulses with rxd 0xF0 then 0x0F;
  - master sees 0x12, 0x34;
  - exactly two tx_load pulses.
- Abort: CS raised after 5 sample edges:
  - aborted pulses once, no rx_valid, rxd keeps its previous value;
  - the next full transfer of 0x81 is received correctly.
- CPOL=0, CPHA=0, W=26: master sends 0x151_4271, txd=0x2AA_AAAA:
  - rxd=0x151_4271;
  - master captures 0x2AA_AAAA; first bit valid before the first rising edge.
- Reset asserted mid-word (after 3 bits), then released:
  - all outputs at reset values, no aborted pulse;
  - the subsequent 0x5A transfer is received correctly.
- SCLK toggling 8 edges with CS high: no rx_valid or tx_load, miso_oe=0 throughout.
